// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
//
// Holds the arbiter FSM state encoding, the default bus widths and the
// master index constants that gnt is compared against.
// Optional feature macro used by the bundle: DMEM_ARB_STARVE_EN.

package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // gnt encoding: which master owns the current access
    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - winner selection between the CPU and debug masters
//
// Purpose: combinational pick of the next granted master. Master 0 (CPU)
// has fixed priority. With DMEM_ARB_STARVE_EN defined, a loss counter for
// master 1 forces a master-1 win once it reaches STARVE_MAX; without the
// macro no counter (and no clock/reset) exists.
//
// Ports:
//   clk, rst_n   in   clock / async active-low reset (DMEM_ARB_STARVE_EN only)
//   arb_en       in   FSM is in IDLE, this cycle is an arbitration (DMEM_ARB_STARVE_EN only)
//   m0_req       in   master 0 request
//   m1_req       in   master 1 request
//   win          out  winning master index (M_CPU / M_DBG)
//   any_req      out  at least one master is requesting

module dmem_arb_pick
    import dmem_arb_pkg::*;
`ifdef DMEM_ARB_STARVE_EN
#(
    parameter int STARVE_MAX = 4
)
`endif
(
`ifdef DMEM_ARB_STARVE_EN
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
`endif
    input  logic m0_req,
    input  logic m1_req,
    output logic win,
    output logic any_req
);

    assign any_req = m0_req | m1_req;

`ifdef DMEM_ARB_STARVE_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starve_hit;

    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_MAX));
    assign win        = (m1_req && (!m0_req || starve_hit)) ? M_DBG : M_CPU;

    // Count only real losses: master 1 asking in an arbitration cycle and
    // master 0 taking it. The hit condition forces a win, so the counter
    // never runs past STARVE_MAX.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (arb_en && m1_req) begin
            if (win == M_DBG) begin
                starve_cnt_d = '0;
            end else if (!starve_hit) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign win = (m1_req && !m0_req) ? M_DBG : M_CPU;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master req/ack arbiter in front of Data_Memory
//
// Purpose: serialises CPU (master 0) and debug/DMA (master 1) accesses onto
// the single-ported data memory with an IDLE -> ACC -> ACK sequence (one
// access per 3 cycles). Read data is captured at the edge closing ACC into
// a per-master register. Memory outputs are decoded from the state register
// alone, so asserting rst_n clears them immediately.
// Optional feature macro: DMEM_ARB_STARVE_EN (master-1 starvation guard).
//
// Ports:
//   clk, rst_n                  in   clock / async active-low reset
//   m0_req/we/addr/wdata        in   master 0 request, direction, address, write data
//   m1_req/we/addr/wdata        in   master 1 request, direction, address, write data
//   m0_ack, m1_ack              out  one-cycle completion pulse
//   m0_rdata, m1_rdata          out  registered read data
//   mem_access_addr             out  memory address
//   mem_write_data              out  memory write data
//   mem_write_en                out  memory write enable
//   mem_read                    out  memory read enable
//   mem_read_data               in   memory combinational read data

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              win;
    logic              any_req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_en  (state_q == IDLE),
        .m0_req  (m0_req),
        .m1_req  (m1_req),
        .win     (win),
        .any_req (any_req)
    );
`else
    dmem_arb_pick u_pick (
        .m0_req  (m0_req),
        .m1_req  (m1_req),
        .win     (win),
        .any_req (any_req)
    );
`endif

    // Request fields follow the latched grant, not the live reqs, so a
    // master dropping req mid-access cannot redirect an access in flight.
    assign sel_we    = (gnt_q == M_DBG) ? m1_we    : m0_we;
    assign sel_addr  = (gnt_q == M_DBG) ? m1_addr  : m0_addr;
    assign sel_wdata = (gnt_q == M_DBG) ? m1_wdata : m0_wdata;

    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        m0_rdata_d      = m0_rdata_q;
        m1_rdata_d      = m1_rdata_q;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        m0_ack          = 1'b0;
        m1_ack          = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = win;
                    state_d = ACC;
                end
            end
            ACC: begin
                mem_access_addr = sel_addr;
                mem_write_data  = sel_wdata;
                mem_write_en    = sel_we;
                mem_read        = !sel_we;
                if (!sel_we) begin
                    if (gnt_q == M_DBG) begin
                        m1_rdata_d = mem_read_data;
                    end else begin
                        m0_rdata_d = mem_read_data;
                    end
                end
                state_d = ACK;
            end
            ACK: begin
                m0_ack  = (gnt_q == M_CPU);
                m1_ack  = (gnt_q == M_DBG);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= M_CPU;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
//
// Models Data_Memory as a 16-word array with combinational read and
// clocked write. Expectations follow DMEM_ARB_STARVE_EN when defined.

module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_ack, m1_ack;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] mem_access_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en, mem_read;
    logic [DATA_W-1:0] mem_read_data;

    logic [DATA_W-1:0] mem [0:15] = '{default: 16'h0000};

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int m0_ack_cnt = 0;
    int m1_ack_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m0_req          (m0_req),
        .m0_we           (m0_we),
        .m0_addr         (m0_addr),
        .m0_wdata        (m0_wdata),
        .m1_req          (m1_req),
        .m1_we           (m1_we),
        .m1_addr         (m1_addr),
        .m1_wdata        (m1_wdata),
        .m0_ack          (m0_ack),
        .m1_ack          (m1_ack),
        .m0_rdata        (m0_rdata),
        .m1_rdata        (m1_rdata),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    assign mem_read_data = mem[mem_access_addr[3:0]];

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_access_addr[3:0]] <= mem_write_data;
    end

    always @(negedge clk) begin
        if (mem_write_en) we_cnt <= we_cnt + 1;
        if (m0_ack) m0_ack_cnt <= m0_ack_cnt + 1;
        if (m1_ack) m1_ack_cnt <= m1_ack_cnt + 1;
    end

    task automatic access(input logic m, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, output int lat);
        @(posedge clk); #1;
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((m ? m1_ack : m0_ack) === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'd0; m0_wdata = 16'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'd0; m1_wdata = 16'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_ack, m1_ack, m0_rdata, m1_rdata, mem_access_addr, mem_write_data,
                 mem_write_en, mem_read} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: ack=%b%b rdata=%h/%h mem_we=%b mem_rd=%b, required all 0",
                         i, m0_ack, m1_ack, m0_rdata, m1_rdata, mem_write_en, mem_read);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m1_ack === 1'b1) begin
                checks++; errors++;
                $display("FAIL reset_first_winner: m1_ack at %0d, required m0 first", i);
            end
            if (m0_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL reset_first_ack: latency=%0d, required 2", lat);
        end
    endtask

    task automatic test_write_read();
        int lat, w0, a0, b0;
        @(posedge clk);
        w0 = we_cnt; a0 = m0_ack_cnt; b0 = m1_ack_cnt;
        access(1'b0, 1'b1, 16'd3, 16'hA5C3, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL wr_latency: %0d, required 2", lat); end
        checks++;
        if (mem[3] !== 16'hA5C3) begin errors++; $display("FAIL wr_commit: mem[3]=%h, required a5c3", mem[3]); end
        access(1'b0, 1'b0, 16'd3, 16'h0000, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL rd_latency: %0d, required 2", lat); end
        checks++;
        if (m0_rdata !== 16'hA5C3) begin errors++; $display("FAIL rd_m0_rdata: %h, required a5c3", m0_rdata); end
        checks++;
        if (m1_rdata !== 16'h0000) begin errors++; $display("FAIL rd_m1_rdata: %h, required 0000", m1_rdata); end
        @(posedge clk);
        checks++;
        if (we_cnt - w0 !== 1) begin errors++; $display("FAIL wr_we_cycles: %0d, required 1", we_cnt - w0); end
        checks++;
        if (m0_ack_cnt - a0 !== 2) begin errors++; $display("FAIL wr_m0_acks: %0d, required 2", m0_ack_cnt - a0); end
        checks++;
        if (m1_ack_cnt - b0 !== 0) begin errors++; $display("FAIL wr_m1_acks: %0d, required 0", m1_ack_cnt - b0); end
    endtask

    task automatic test_simultaneous();
        int lat, l0, l1;
        access(1'b0, 1'b1, 16'd1, 16'h1234, lat);
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'd1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'd1; m1_wdata = 16'h0F0F;
        l0 = -1; l1 = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (m0_ack === 1'b1 && l0 < 0) begin l0 = i; m0_req = 1'b0; end
            if (m1_ack === 1'b1 && l1 < 0) begin l1 = i; m1_req = 1'b0; end
            if (l0 >= 0 && l1 >= 0) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checks++;
        if (l0 !== 2) begin errors++; $display("FAIL sim_m0_ack_cycle: %0d, required 2", l0); end
        checks++;
        if (l1 !== 5) begin errors++; $display("FAIL sim_m1_ack_cycle: %0d, required 5", l1); end
        checks++;
        if (m0_rdata !== 16'h1234) begin errors++; $display("FAIL sim_m0_old_data: %h, required 1234", m0_rdata); end
        checks++;
        if (mem[1] !== 16'h0F0F) begin errors++; $display("FAIL sim_m1_write: mem[1]=%h, required 0f0f", mem[1]); end
        checks++;
        if (m1_rdata !== 16'h0000) begin errors++; $display("FAIL sim_m1_rdata: %h, required 0000", m1_rdata); end
    endtask

    task automatic test_starvation();
        int n0, l1, exp_l1, exp_n0;
`ifdef DMEM_ARB_STARVE_EN
        exp_l1 = 14; exp_n0 = 4;
`else
        exp_l1 = 32; exp_n0 = 10;
`endif
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'd3;
        n0 = 0; l1 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m0_ack === 1'b1) n0++;
            if (m1_ack === 1'b1) begin
                l1 = i;
                break;
            end
`ifndef DMEM_ARB_STARVE_EN
            if (i == 29) m0_req = 1'b0;
`endif
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checks++;
        if (l1 !== exp_l1) begin errors++; $display("FAIL starve_m1_ack_cycle: %0d, required %0d", l1, exp_l1); end
        checks++;
        if (n0 !== exp_n0) begin errors++; $display("FAIL starve_m0_acks: %0d, required %0d", n0, exp_n0); end
        checks++;
        if (m1_rdata !== 16'hA5C3) begin errors++; $display("FAIL starve_m1_rdata: %h, required a5c3", m1_rdata); end
        checks++;
        if (m0_rdata !== 16'h0F0F) begin errors++; $display("FAIL starve_m0_rdata: %h, required 0f0f", m0_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int lat;
        access(1'b1, 1'b1, 16'd6, 16'h1111, lat);
        checks++;
        if (mem[6] !== 16'h1111) begin errors++; $display("FAIL mid_preload: mem[6]=%h, required 1111", mem[6]); end
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'd6; m0_wdata = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_write_en !== 1'b1) begin errors++; $display("FAIL mid_in_acc: mem_write_en=%b, required 1", mem_write_en); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_write_en, mem_read, mem_access_addr, mem_write_data} !== '0) begin
            errors++;
            $display("FAIL mid_async_clear: we=%b rd=%b addr=%h wdata=%h, required 0",
                     mem_write_en, mem_read, mem_access_addr, mem_write_data);
        end
        m0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_ack cycle %0d: ack=%b%b, required 00", i, m0_ack, m1_ack);
            end
        end
        checks++;
        if (mem[6] !== 16'h1111) begin errors++; $display("FAIL mid_no_write: mem[6]=%h, required 1111", mem[6]); end
        checks++;
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL mid_state: %0d, required IDLE", dut.state_q); end
        checks++;
        if (m0_rdata !== 16'h0 || m1_rdata !== 16'h0) begin
            errors++;
            $display("FAIL mid_rdata_clear: %h/%h, required 0000/0000", m0_rdata, m1_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_write_isolation();
        int lat;
        access(1'b1, 1'b0, 16'd3, 16'h0000, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL iso_rd_latency: %0d, required 2", lat); end
        checks++;
        if (m1_rdata !== 16'hA5C3) begin errors++; $display("FAIL iso_rd_data: %h, required a5c3", m1_rdata); end
        access(1'b1, 1'b1, 16'd5, 16'h5A5A, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL iso_wr_latency: %0d, required 2", lat); end
        checks++;
        if (m1_rdata !== 16'hA5C3) begin errors++; $display("FAIL iso_rdata_kept: %h, required a5c3", m1_rdata); end
        checks++;
        if (mem[5] !== 16'h5A5A) begin errors++; $display("FAIL iso_commit: mem[5]=%h, required 5a5a", mem[5]); end
        checks++;
        if (m0_rdata !== 16'h0000) begin errors++; $display("FAIL iso_m0_rdata: %h, required 0000", m0_rdata); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid_access();
        test_write_isolation();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
